control_sequencer: RTL and testbench

Hardwired control unit that sequences the single-bus CPU datapath through fetch and execute T-steps. It decodes the instruction register and drives every datapath control input: register-select and bus-drive strobes, the register enable vector, bus source selects, ALU op code, and RAM/MDR controls. It sits beside the datapath at CPU top level. It is the only master of those control lines once `start` is issued.

---
 rtl/control_sequencer.sv | 159 +++++++++++++++
 tb/tb_control_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the single-bus CPU datapath.
// Steps the datapath through fetch (T0-T3) and execute (T4-T9) T-steps,
// decoding ir[31:27] and driving all datapath control lines.
// Optional feature: define CTRL_SINGLE_STEP_EN to add a `step` input and a
// PAUSE state entered after every completed instruction.
module control_sequencer #(
  parameter logic [4:0] ALU_INC = 5'b11111,
  parameter logic [4:0] ALU_ADD = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic [4:0]  Control_Signals,
  output logic        ReadRAM,
  output logic        WriteRAM,
  output logic        MD_Read,
  output logic        running,
  output logic        halted
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, T8, T9, HALT
`ifdef CTRL_SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t DONE = PAUSE;
`else
  localparam state_t DONE = T0;
`endif

  state_t state, state_nxt;

  // Opcode decode; instruction classes share execute sequences.
  logic [4:0] opcode;
  logic is_alu_rr, is_alu_imm, is_ldi, is_ld, is_st, is_br;
  logic is_in, is_out, is_mfhi, is_mflo, is_halt, is_short, has_exec;
  logic unused_ir;

  assign opcode     = ir[31:27];
  assign unused_ir  = ^ir[26:0];
  assign is_alu_rr  = (opcode >= 5'b00011) && (opcode <= 5'b01011);
  assign is_alu_imm = (opcode >= 5'b01100) && (opcode <= 5'b01110);
  assign is_ldi     = (opcode == 5'b00001);
  assign is_ld      = (opcode == 5'b00000);
  assign is_st      = (opcode == 5'b00010);
  assign is_br      = (opcode == 5'b10011);
  assign is_in      = (opcode == 5'b10110);
  assign is_out     = (opcode == 5'b10111);
  assign is_mfhi    = (opcode == 5'b11000);
  assign is_mflo    = (opcode == 5'b11001);
  assign is_halt    = (opcode == 5'b11011);
  assign is_short   = is_in | is_out | is_mfhi | is_mflo;
  assign has_exec   = is_alu_rr | is_alu_imm | is_ldi | is_ld | is_st | is_br | is_short;

  // State register; clr abandons any instruction in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state sequencing: each instruction class leaves at its last step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = T0;
      T0:   state_nxt = T1;
      T1:   state_nxt = T2;
      T2:   state_nxt = T3;
      T3: begin
        if (is_halt)       state_nxt = HALT;
        else if (has_exec) state_nxt = T4;
        else               state_nxt = DONE;
      end
      T4:   state_nxt = is_short ? DONE : T5;
      T5:   state_nxt = T6;
      T6:   state_nxt = (is_ld | is_st | is_br) ? T7 : DONE;
      T7:   state_nxt = is_ld ? T8 : DONE;
      T8:   state_nxt = T9;
      T9:   state_nxt = DONE;
      HALT: state_nxt = HALT;
`ifdef CTRL_SINGLE_STEP_EN
      PAUSE: if (step) state_nxt = T0;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs decoded from the current step and instruction.
  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    enable = '0; busSelect = '0; Control_Signals = '0;
    ReadRAM = 1'b0; WriteRAM = 1'b0; MD_Read = 1'b0;
    running = (state >= T0) && (state <= T9);
    halted  = (state == HALT);
    case (state)
      T0: begin
        busSelect[20] = 1'b1; enable[25] = 1'b1; enable[18] = 1'b1;
        Control_Signals = ALU_INC;
      end
      T1: begin busSelect[19] = 1'b1; enable[20] = 1'b1; ReadRAM = 1'b1; end
      T2: begin MD_Read = 1'b1; enable[21] = 1'b1; end
      T3: begin busSelect[21] = 1'b1; enable[24] = 1'b1; end
      T4: begin
        if (is_alu_rr | is_alu_imm) begin Grb = 1'b1; Rout = 1'b1; enable[19] = 1'b1; end
        else if (is_ldi | is_ld | is_st) begin Grb = 1'b1; BAout = 1'b1; enable[19] = 1'b1; end
        else if (is_br) begin Gra = 1'b1; Rout = 1'b1; enable[27] = 1'b1; end
        else if (is_in) begin busSelect[22] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_out) begin Gra = 1'b1; Rout = 1'b1; enable[26] = 1'b1; end
        else if (is_mfhi) begin busSelect[16] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_mflo) begin busSelect[17] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      T5: begin
        if (is_alu_rr) begin
          Grc = 1'b1; Rout = 1'b1; Control_Signals = opcode; enable[18] = 1'b1;
        end else if (is_alu_imm) begin
          busSelect[23] = 1'b1; Control_Signals = opcode; enable[18] = 1'b1;
        end else if (is_ldi | is_ld | is_st) begin
          busSelect[23] = 1'b1; Control_Signals = ALU_ADD; enable[18] = 1'b1;
        end else if (is_br) begin
          busSelect[20] = 1'b1; enable[19] = 1'b1;
        end
      end
      T6: begin
        if (is_alu_rr | is_alu_imm | is_ldi) begin
          busSelect[19] = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_ld | is_st) begin
          busSelect[19] = 1'b1; enable[25] = 1'b1;
        end else if (is_br) begin
          busSelect[23] = 1'b1; Control_Signals = ALU_ADD; enable[18] = 1'b1;
        end
      end
      T7: begin
        if (is_ld) ReadRAM = 1'b1;
        else if (is_st) begin Gra = 1'b1; Rout = 1'b1; WriteRAM = 1'b1; end
        else if (is_br) begin busSelect[19] = 1'b1; enable[20] = con_ff; end
      end
      T8: begin MD_Read = 1'b1; enable[21] = 1'b1; end
      T9: begin busSelect[21] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: linear sequence of steps with
// hand-computed expected control vectors checked by immediate assertions.
module tb_control_sequencer;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic [31:0] ir = '0;
  logic        con_ff = 1'b0;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic [31:0] enable, busSelect;
  logic [4:0]  Control_Signals;
  logic        ReadRAM, WriteRAM, MD_Read, running, halted;

  int n_cmp = 0;
  int n_mis = 0;

  // Bit positions inside the packed strobe vector below.
  localparam int GRA = 10, GRB = 9, GRC = 8, RIN = 7, ROUT = 6, BAOUT = 5;
  localparam int RD = 4, WR = 3, MDR = 2, RUN = 1, HLT = 0;

  logic [10:0] strobes;
  assign strobes = {Gra, Grb, Grc, Rin, Rout, BAout, ReadRAM, WriteRAM, MD_Read, running, halted};

  control_sequencer dut (
    .clk(clk), .clr(clr), .start(start),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .ir(ir), .con_ff(con_ff),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .enable(enable), .busSelect(busSelect), .Control_Signals(Control_Signals),
    .ReadRAM(ReadRAM), .WriteRAM(WriteRAM), .MD_Read(MD_Read),
    .running(running), .halted(halted)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [31:0] b(int i);
    return 32'd1 << i;
  endfunction

  function automatic logic [10:0] s(int i);
    return 11'd1 << i;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Check one T-step's outputs (running implied), then advance a clock.
  task automatic step_chk(string tag, logic [10:0] st, logic [31:0] en,
                          logic [31:0] bus, logic [4:0] cs);
    chk({tag, ".strobe"}, 32'(strobes), 32'(st | s(RUN)));
    chk({tag, ".en"}, enable, en);
    chk({tag, ".bus"}, busSelect, bus);
    chk({tag, ".cs"}, 32'(Control_Signals), 32'(cs));
    tick;
  endtask

  // Outputs in a non-running state: everything 0 except possibly halted.
  task automatic quiet_chk(string tag, logic exp_halt);
    chk({tag, ".strobe"}, 32'(strobes), exp_halt ? 32'(s(HLT)) : 32'd0);
    chk({tag, ".en"}, enable, 32'd0);
    chk({tag, ".bus"}, busSelect, 32'd0);
    chk({tag, ".cs"}, 32'(Control_Signals), 32'd0);
  endtask

  task automatic fetch(string tag);
    step_chk({tag, ".t0"}, '0, b(25) | b(18), b(20), 5'b11111);
    step_chk({tag, ".t1"}, s(RD), b(20), b(19), 5'd0);
    step_chk({tag, ".t2"}, s(MDR), b(21), 32'd0, 5'd0);
    step_chk({tag, ".t3"}, '0, b(24), b(21), 5'd0);
  endtask

  // After an instruction's last step: continuous mode is already in T0;
  // single-step mode sits in PAUSE until step is sampled high.
  task automatic inst_end(string tag);
`ifdef CTRL_SINGLE_STEP_EN
    quiet_chk({tag, ".pause0"}, 1'b0);
    tick;
    quiet_chk({tag, ".pause1"}, 1'b0);
    step = 1'b1;
    tick;
    step = 1'b0;
`else
    chk({tag, ".next_t0"}, 32'(running), 32'd1);
`endif
  endtask

  initial begin
    // Reset: asynchronous, outputs 0 without a clock edge.
    #1 clr = 1'b1;
    #2 quiet_chk("reset", 1'b0);
    @(negedge clk);
    clr = 1'b0;
    #1 quiet_chk("idle", 1'b0);

    // add R1,R2,R3
    ir = 32'h18908000;
    start = 1'b1;
    tick;
    start = 1'b0;
    fetch("add");
    step_chk("add.t4", s(GRB) | s(ROUT), b(19), 32'd0, 5'd0);
    step_chk("add.t5", s(GRC) | s(ROUT), b(18), 32'd0, 5'b00011);
    step_chk("add.t6", s(GRA) | s(RIN), 32'd0, b(19), 5'd0);
    inst_end("add");

    // Second add, abandoned by clr while in T5.
    fetch("add2");
    step_chk("add2.t4", s(GRB) | s(ROUT), b(19), 32'd0, 5'd0);
    clr = 1'b1;
    #1 quiet_chk("clr_t5", 1'b0);
    #1 clr = 1'b0;
    tick;
    quiet_chk("clr_idle", 1'b0);

    // ld: restart from IDLE, then full 10-step sequence.
    ir = {5'b00000, 27'h0123456};
    start = 1'b1;
    tick;
    start = 1'b0;
    fetch("ld");
    step_chk("ld.t4", s(GRB) | s(BAOUT), b(19), 32'd0, 5'd0);
    step_chk("ld.t5", '0, b(18), b(23), 5'b00011);
    step_chk("ld.t6", '0, b(25), b(19), 5'd0);
    step_chk("ld.t7", s(RD), 32'd0, 32'd0, 5'd0);
    step_chk("ld.t8", s(MDR), b(21), 32'd0, 5'd0);
    step_chk("ld.t9", s(GRA) | s(RIN), 32'd0, b(21), 5'd0);
    inst_end("ld");

    // st
    ir = {5'b00010, 27'h0000abc};
    fetch("st");
    step_chk("st.t4", s(GRB) | s(BAOUT), b(19), 32'd0, 5'd0);
    step_chk("st.t5", '0, b(18), b(23), 5'b00011);
    step_chk("st.t6", '0, b(25), b(19), 5'd0);
    step_chk("st.t7", s(GRA) | s(ROUT) | s(WR), 32'd0, 32'd0, 5'd0);
    inst_end("st");

    // Branch with condition false, then true.
    for (int c = 0; c < 2; c++) begin
      ir = {5'b10011, 27'h0000010};
      con_ff = c[0];
      fetch("br");
      step_chk("br.t4", s(GRA) | s(ROUT), b(27), 32'd0, 5'd0);
      step_chk("br.t5", '0, b(19), b(20), 5'd0);
      step_chk("br.t6", '0, b(18), b(23), 5'b00011);
      step_chk(c == 0 ? "br0.t7" : "br1.t7", '0, c == 0 ? 32'd0 : b(20), b(19), 5'd0);
      inst_end("br");
    end
    con_ff = 1'b0;

    // Immediate ALU (andi-class opcode 01100) and ldi.
    ir = {5'b01100, 27'h0000007};
    fetch("imm");
    step_chk("imm.t4", s(GRB) | s(ROUT), b(19), 32'd0, 5'd0);
    step_chk("imm.t5", '0, b(18), b(23), 5'b01100);
    step_chk("imm.t6", s(GRA) | s(RIN), 32'd0, b(19), 5'd0);
    inst_end("imm");

    ir = {5'b00001, 27'h0000005};
    fetch("ldi");
    step_chk("ldi.t4", s(GRB) | s(BAOUT), b(19), 32'd0, 5'd0);
    step_chk("ldi.t5", '0, b(18), b(23), 5'b00011);
    step_chk("ldi.t6", s(GRA) | s(RIN), 32'd0, b(19), 5'd0);
    inst_end("ldi");

    // Single-step T4 instructions.
    ir = {5'b10110, 27'h0};
    fetch("in");
    step_chk("in.t4", s(GRA) | s(RIN), 32'd0, b(22), 5'd0);
    inst_end("in");
    ir = {5'b10111, 27'h0};
    fetch("out");
    step_chk("out.t4", s(GRA) | s(ROUT), b(26), 32'd0, 5'd0);
    inst_end("out");
    ir = {5'b11000, 27'h0};
    fetch("mfhi");
    step_chk("mfhi.t4", s(GRA) | s(RIN), 32'd0, b(16), 5'd0);
    inst_end("mfhi");
    ir = {5'b11001, 27'h0};
    fetch("mflo");
    step_chk("mflo.t4", s(GRA) | s(RIN), 32'd0, b(17), 5'd0);
    inst_end("mflo");

    // nop and an unimplemented opcode (mul) go straight back after T3.
    ir = {5'b11010, 27'h0};
    fetch("nop");
    inst_end("nop");
    ir = {5'b01111, 27'h0};
    fetch("mul");
    inst_end("mul");

    // halt: HALT after T3, start ignored.
    ir = {5'b11011, 27'h0};
    fetch("halt");
    quiet_chk("halt", 1'b1);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      quiet_chk("halt_start", 1'b1);
    end
    start = 1'b0;
    clr = 1'b1;
    #1 quiet_chk("halt_clr", 1'b0);
    clr = 1'b0;
    tick;
    quiet_chk("post_clr_idle", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
